// File: rtl/axi_io_mem_responder.sv
// axi_io_mem_responder: single-outstanding line-store responder for the AXI IO
// request port. Accepts one request, waits a latency, pulses ready for one cycle,
// then waits for valid to drop before accepting the next request.
// Optional macro YSYX210544_MEM_RESP_RAND_DELAY_EN adds a pseudo-random
// 0..7 cycle extra latency taken from an 8-bit LFSR.
module axi_io_mem_responder #(
  parameter int          LINES     = 64,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_axi_io_valid,
  input  logic         i_axi_io_op,
  input  logic [511:0] i_axi_io_wdata,
  input  logic [63:0]  i_axi_io_addr,
  input  logic [1:0]   i_axi_io_size,
  input  logic [7:0]   i_axi_io_blks,
  output logic         o_axi_io_ready,
  output logic [511:0] o_axi_io_rdata
);

  localparam int          IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [63:0] SPAN  = 64'(LINES) * 64'd64;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;

  state_t         state;
  state_t         state_next;
  logic           accept;
  logic           op_q;
  logic [511:0]   wdata_q;
  logic [63:0]    addr_q;
  logic [2:0]     blks_q;
  logic [2:0]     lat_cnt;
  logic [2:0]     lat_load;
  logic [63:0]    offset;
  logic           in_range;
  logic [IDX_W-1:0] line_idx;
  logic [7:0]     word_mask;
  logic [511:0]   lane_mask;
  logic [511:0]   store [LINES];
  logic           unused_inputs;

  // Beat size is always treated as 8 bytes and only the low 3 blks bits count.
  assign unused_inputs = ^{i_axi_io_size, i_axi_io_blks[7:3]};

  assign accept = (state == IDLE) && i_axi_io_valid;

`ifdef YSYX210544_MEM_RESP_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR (taps 8,6,5,4) stepped once per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign lat_load = lfsr[2:0];
`else
  assign lat_load = 3'd0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: HOLD blocks a still-high valid from starting a new request.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (i_axi_io_valid) state_next = BUSY;
      BUSY: if (lat_cnt == 3'd0) state_next = RESP;
      RESP: state_next = HOLD;
      HOLD: if (!i_axi_io_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request at accept so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= i_axi_io_op;
      wdata_q <= i_axi_io_wdata;
      addr_q  <= i_axi_io_addr;
      blks_q  <= i_axi_io_blks[2:0];
    end
  end

  // Latency counter: loaded at accept, counts down while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= 3'd0;
    end else if (accept) begin
      lat_cnt <= lat_load;
    end else if (state == BUSY && lat_cnt != 3'd0) begin
      lat_cnt <= lat_cnt - 3'd1;
    end
  end

  // Address decode: range check against the window and line index within it.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
    line_idx = offset[6 +: IDX_W];
  end

  // Word lanes touched by the burst, wrapping inside the 8-word line.
  always_comb begin
    word_mask = 8'd0;
    lane_mask = '0;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) <= blks_q) begin
        word_mask[addr_q[5:3] + 3'(k)] = 1'b1;
      end
    end
    for (int w = 0; w < 8; w++) begin
      lane_mask[64*w +: 64] = {64{word_mask[w]}};
    end
  end

  // Outputs: ready and read data only in RESP, suppressed by a reset in that cycle.
  always_comb begin
    o_axi_io_ready = 1'b0;
    o_axi_io_rdata = '0;
    if (state == RESP && !rst) begin
      o_axi_io_ready = 1'b1;
      if (!op_q && in_range) begin
        o_axi_io_rdata = store[line_idx] & lane_mask;
      end
    end
  end

  // Store update: merge the transferred lanes in the RESP cycle; never reset.
  always_ff @(posedge clk) begin
    if (state == RESP && !rst && op_q && in_range) begin
      store[line_idx] <= (store[line_idx] & ~lane_mask) | (wdata_q & lane_mask);
    end
  end

endmodule

// File: tb/tb_axi_io_mem_responder.sv
// tb_axi_io_mem_responder: randomized scoreboard bench for axi_io_mem_responder.
// A word-level reference store predicts read data and latency at issue time;
// a negedge monitor pops predictions whenever ready is seen.
module tb_axi_io_mem_responder;

  localparam int          LINES = 64;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;

  logic         clk;
  logic         rst;
  logic         i_axi_io_valid;
  logic         i_axi_io_op;
  logic [511:0] i_axi_io_wdata;
  logic [63:0]  i_axi_io_addr;
  logic [1:0]   i_axi_io_size;
  logic [7:0]   i_axi_io_blks;
  logic         o_axi_io_ready;
  logic [511:0] o_axi_io_rdata;

  axi_io_mem_responder #(.LINES(LINES), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_axi_io_valid (i_axi_io_valid),
    .i_axi_io_op    (i_axi_io_op),
    .i_axi_io_wdata (i_axi_io_wdata),
    .i_axi_io_addr  (i_axi_io_addr),
    .i_axi_io_size  (i_axi_io_size),
    .i_axi_io_blks  (i_axi_io_blks),
    .o_axi_io_ready (o_axi_io_ready),
    .o_axi_io_rdata (o_axi_io_rdata)
  );

  typedef struct {
    logic [511:0] rdata;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem [LINES][8];
  logic [7:0]  ref_lfsr = 8'hA5;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          first_release = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure request-to-ready latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Extra latency the design should add for the next accepted request.
  function automatic int next_lat();
    int l;
    l = 0;
`ifdef YSYX210544_MEM_RESP_RAND_DELAY_EN
    l = int'(ref_lfsr[2:0]);
    ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
`endif
    return l;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int j = 0; j < 16; j++) v[32*j +: 32] = $urandom();
    return v;
  endfunction

  // Compare one completed response against its prediction.
  task automatic check_output(input exp_t e);
    int lat_obs;
    checks++;
    if (o_axi_io_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL rdata: got %h expected %h", o_axi_io_rdata, e.rdata);
    end
    lat_obs = cyc + 1 - e.acc_cyc;
    checks++;
    if (lat_obs != 2 + e.lat) begin
      errors++;
      $display("[TB] FAIL latency: got %0d expected %0d", lat_obs, 2 + e.lat);
    end
  endtask

  // Monitor: every ready must match a queued prediction; otherwise rdata is zero.
  always @(negedge clk) begin
    if (o_axi_io_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ready: got ready=1 expected no pending request");
      end else begin
        check_output(sb.pop_front());
      end
    end else begin
      checks++;
      if (o_axi_io_rdata !== '0) begin
        errors++;
        $display("[TB] FAIL idle_rdata: got %h expected 0", o_axi_io_rdata);
      end
    end
  end

  // Issue one request, predict its outcome, and wait for completion.
  task automatic apply_stimulus(input logic op, input logic [63:0] addr,
                                input logic [7:0] blks, input logic [1:0] size,
                                input logic [511:0] wdata, input int hold,
                                input bit rst_after);
    exp_t         e;
    logic [511:0] exp_rd;
    bit           inr;
    bit           got;
    int           line;
    int           start;
    int           w;
    @(negedge clk);
    i_axi_io_valid = 1'b1;
    i_axi_io_op    = op;
    i_axi_io_addr  = addr;
    i_axi_io_blks  = blks;
    i_axi_io_size  = size;
    i_axi_io_wdata = wdata;
    if (first_release) begin
      rst = 1'b0;
      first_release = 1'b0;
    end
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    e.lat     = next_lat();
    i_axi_io_op    = 1'($urandom());
    i_axi_io_addr  = {$urandom(), $urandom()};
    i_axi_io_blks  = 8'($urandom());
    i_axi_io_wdata = rand_line();
    if (rst_after) begin
      rst = 1'b1;
      i_axi_io_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ref_lfsr = 8'hA5;
      repeat (3) @(negedge clk);
      return;
    end
    inr    = (addr >= BASE) && (addr < BASE + 64'(LINES) * 64);
    exp_rd = '0;
    if (inr) begin
      line  = int'((addr - BASE) / 64);
      start = int'((addr % 64) / 8);
      for (int k = 0; k <= int'(blks % 8); k++) begin
        w = (start + k) % 8;
        if (op) mem[line][w] = wdata[64*w +: 64];
        else    exp_rd[64*w +: 64] = mem[line][w];
      end
    end
    e.rdata = exp_rd;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (o_axi_io_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got no ready in 40 cycles expected one pulse");
      if (sb.size() > 0) void'(sb.pop_back());
    end
    repeat (hold) @(negedge clk);
    i_axi_io_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      return BASE - 64'($urandom_range(1, 4096));
    else if (r == 1) return BASE + 64'(LINES) * 64 + 64'($urandom_range(0, 8191));
    else             return BASE + 64'($urandom_range(0, LINES * 64 - 1));
  endfunction

  initial begin
    logic [511:0] pat;
    rst = 1'b1;
    i_axi_io_valid = 1'b0;
    i_axi_io_op = 1'b0;
    i_axi_io_addr = '0;
    i_axi_io_blks = '0;
    i_axi_io_size = 2'b11;
    i_axi_io_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_axi_io_ready !== 1'b0 || o_axi_io_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b expected 0 with zero rdata", o_axi_io_ready);
    end

    // Full-line write to line 0, released from reset on the accepting edge.
    for (int w = 0; w < 8; w++) pat[64*w +: 64] = 64'h0123_4567_0000_0000 | 64'(8 * w);
    apply_stimulus(1'b1, BASE, 8'd7, 2'b11, pat, 0, 1'b0);
    for (int l = 1; l < LINES; l++)
      apply_stimulus(1'b1, BASE + 64'(l) * 64, 8'd7, 2'($urandom()), rand_line(), 0, 1'b0);
    apply_stimulus(1'b0, BASE, 8'd7, 2'b11, '0, 0, 1'b0);

    // Wrapping read, single-word write, confirming full read.
    apply_stimulus(1'b0, BASE + 64'h38, 8'd1, 2'b11, '0, 0, 1'b0);
    pat = rand_line();
    pat[128 +: 64] = 64'hDEAD_BEEF;
    apply_stimulus(1'b1, BASE + 64'h10, 8'd0, 2'b11, pat, 0, 1'b0);
    apply_stimulus(1'b0, BASE, 8'd7, 2'b11, '0, 0, 1'b0);

    // Out-of-range read and write, then confirm line 0 untouched.
    apply_stimulus(1'b0, 64'h7FFF_FFC0, 8'd7, 2'b11, '0, 0, 1'b0);
    apply_stimulus(1'b1, BASE + 64'h1000, 8'd7, 2'b11, rand_line(), 0, 1'b0);
    apply_stimulus(1'b0, BASE, 8'd7, 2'b11, '0, 0, 1'b0);

    // Reset while a write is pending, then line 1 must be intact.
    apply_stimulus(1'b1, BASE + 64'h40, 8'd7, 2'b11, rand_line(), 0, 1'b1);
    apply_stimulus(1'b0, BASE + 64'h40, 8'd7, 2'b11, '0, 0, 1'b0);

    // Back-to-back reads with valid held into HOLD.
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b0, BASE + 64'(i) * 64, 8'd7, 2'b11, '0, 2, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++)
      apply_stimulus(1'($urandom()), rand_addr(), 8'($urandom()), 2'($urandom()),
                     rand_line(), $urandom_range(0, 3), 1'b0);

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover: got %0d pending predictions expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected end before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
